sect163r1_pt_mul_unload: RTL and testbench

SECT163R1_PT_MUL_UNLOAD -- requirements
Module: sect163r1_pt_mul_unload

---
 rtl/sect163r1_pt_mul_unload.sv | 110 +++++++++++
 tb/tb_sect163r1_pt_mul_unload.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sect163r1_pt_mul_unload.sv
// Result unloader for sect163r1_pt_mul: captures {y,x} on the rising edge of done_i
// and streams it out as 2*NW ready/valid words, x first, least-significant word first.
module sect163r1_pt_mul_unload #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          done_i,
    input  logic [162:0]  x_i,
    input  logic [162:0]  y_i,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          ovf
);

    localparam int NW     = (163 + DW - 1) / DW;
    localparam int NWORDS = 2 * NW;
    localparam int CW     = NW * DW;
    localparam int IW     = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        r_state;
    logic [IW-1:0]                 r_idx;
    logic [NWORDS-1:0][DW-1:0]     r_buf;
    logic                          r_done_d;
    logic                          r_ovf;

    state_t                        w_nstate;
    logic [IW-1:0]                 w_nidx;
    logic                          w_novf;
    logic                          w_load;
    logic                          w_cap;
    logic                          w_xfer;
    logic                          w_final;
    logic                          w_send;

    assign w_send  = (r_state == SEND);
    assign w_cap   = done_i & ~r_done_d;
    assign w_xfer  = w_send & out_ready;
    assign w_final = w_xfer & (r_idx == LAST_IDX);

    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx;
        w_novf   = r_ovf;
        w_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cap) begin
                    w_load   = 1'b1;
                    w_nidx   = '0;
                    w_nstate = SEND;
                end
            end
            SEND: begin
                if (w_cap && w_final) begin
                    // back-to-back result: reload without a bubble
                    w_load = 1'b1;
                    w_nidx = '0;
                end else begin
                    if (w_cap)
                        w_novf = 1'b1;
                    if (w_final) begin
                        w_nstate = IDLE;
                        w_nidx   = '0;
                    end else if (w_xfer) begin
                        w_nidx = r_idx + 1'b1;
                    end
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_buf    <= '0;
            r_done_d <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (clr) begin
            // done_d follows done_i so a level already high is not seen as an edge
            r_state  <= IDLE;
            r_idx    <= '0;
            r_done_d <= done_i;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_idx    <= w_nidx;
            r_done_d <= done_i;
            r_ovf    <= w_novf;
            if (w_load)
                r_buf <= {CW'(y_i), CW'(x_i)};
        end
    end

    assign out_valid = w_send;
    assign busy      = w_send;
    assign out_last  = w_send && (r_idx == LAST_IDX);
    assign out_data  = w_send ? r_buf[r_idx] : '0;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_sect163r1_pt_mul_unload.sv
// Directed bench for sect163r1_pt_mul_unload: word table, stalls, overflow,
// back-to-back reload, mid-stream reset and held done_i.
module tb_sect163r1_pt_mul_unload;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          done_i;
    logic [162:0]  x_i;
    logic [162:0]  y_i;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          ovf;

    sect163r1_pt_mul_unload #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .done_i(done_i),
        .x_i(x_i), .y_i(y_i),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } vec_t;

    localparam logic [162:0] XA = 163'h1_23456789_ABCDEF01_23456789_ABCDEF01_23456789;
    localparam logic [162:0] YA = {163{1'b1}};

    vec_t        tbl [12];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc    = 0;
    int          stall_err = 0;
    logic [31:0] q_data [$];
    logic        q_last [$];
    int          q_cyc  [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [3:0]  rdy_pat = 4'b1001;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (out_data !== prev_data || out_last !== prev_last || out_valid !== 1'b1))
                stall_err++;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                q_cyc.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic qclear();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic compare_seq(input string nm, input int exp_n);
        chk({nm, "_count"}, q_data.size(), exp_n);
        for (int i = 0; i < 12; i++) begin
            if (i < q_data.size()) begin
                chk($sformatf("%s_w%0d", nm, i), q_data[i], tbl[i].data);
                chk($sformatf("%s_l%0d", nm, i), q_last[i], tbl[i].last);
            end
        end
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            tbl[i].data = (i % 2 == 0) ? 32'h23456789 : 32'hABCDEF01;
            tbl[i].last = 1'b0;
        end
        tbl[5]  = '{32'h00000001, 1'b0};
        for (int i = 6; i < 11; i++) tbl[i] = '{32'hFFFFFFFF, 1'b0};
        tbl[11] = '{32'h00000007, 1'b1};

        rst_n = 1'b0; clr = 1'b0; done_i = 1'b0; out_ready = 1'b0;
        x_i = XA; y_i = YA;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_last",  out_last,  0);
        chk("rst_busy",  busy,      0);
        chk("rst_ovf",   ovf,       0);
        @(negedge clk) rst_n = 1'b1;
        step(2);
        chk("idle_valid", out_valid, 0);

        // basic stream, ready always high
        out_ready = 1'b1;
        qclear();
        done_i = 1'b1;
        chk("pre_cap_valid", out_valid, 0);
        step(1);
        done_i = 1'b0;
        chk("lat_valid", out_valid, 1);
        chk("lat_data",  out_data,  tbl[0].data);
        chk("lat_busy",  busy,      1);
        step(15);
        compare_seq("basic", 12);
        if (q_cyc.size() == 12) chk("basic_consec", q_cyc[11] - q_cyc[0], 11);
        chk("basic_idle_valid", out_valid, 0);
        chk("basic_idle_busy",  busy,      0);

        // stalls: ready 1,0,0,1 repeating
        qclear();
        stall_err = 0;
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        for (int c = 0; c < 60; c++) begin
            out_ready = rdy_pat[c % 4];
            step(1);
        end
        out_ready = 1'b1;
        step(2);
        compare_seq("stall", 12);
        chk("stall_stable", stall_err, 0);

        // overflow: second edge while word 3 is presented
        qclear();
        pulse_done();
        step(3);
        chk("ovf_pre", ovf, 0);
        pulse_done();
        chk("ovf_set", ovf, 1);
        step(15);
        compare_seq("ovf", 12);
        chk("ovf_sticky", ovf, 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("ovf_clr", ovf, 0);

        // new edge coincides with final transfer
        qclear();
        pulse_done();
        step(11);
        chk("align_last", out_last, 1);
        done_i = 1'b1;
        x_i = 163'h5; y_i = '0;
        step(1);
        done_i = 1'b0;
        chk("align_valid", out_valid, 1);
        chk("align_w0",    out_data,  32'h5);
        chk("align_last0", out_last,  0);
        chk("align_ovf",   ovf,       0);
        step(15);
        compare_seq("align", 24);
        if (q_data.size() == 24) begin
            chk("align2_w0",  q_data[12], 32'h5);
            chk("align2_w11", q_data[23], 32'h0);
            chk("align2_l11", q_last[23], 1);
        end
        x_i = XA; y_i = YA;

        // asynchronous reset during word 7, done_i held across release
        qclear();
        pulse_done();
        step(7);
        chk("rst7_data", out_data, tbl[7].data);
        #2;
        rst_n = 1'b0;
        done_i = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data",  out_data,  0);
        chk("arst_last",  out_last,  0);
        chk("arst_busy",  busy,      0);
        qclear();
        @(negedge clk) rst_n = 1'b1;
        step(15);
        compare_seq("rstcap", 12);
        done_i = 1'b0;
        step(2);

        // done_i held high for 50 cycles, then clr while still high
        qclear();
        done_i = 1'b1;
        step(50);
        compare_seq("held", 12);
        chk("held_ovf", ovf, 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        qclear();
        step(20);
        chk("clr_hi_count", q_data.size(), 0);
        chk("clr_hi_valid", out_valid, 0);
        done_i = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
